// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter slice.
// Holds the adder width, the arbiter state encoding, the owner encoding
// and a small helper that derives two's-complement overflow from the
// carries of the shared ripple adder.
package adder_arbiter_pkg;

    localparam int ADDER_WIDTH = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // The owner encoding doubles as the priority pointer encoding.
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // Signed overflow: carry into the MSB disagrees with the carry out.
    function automatic logic twos_overflow(input logic carry_msb, input logic carry_out);
        return carry_msb ^ carry_out;
    endfunction

endpackage

// File: rtl/adder_arbiter_full_adder.sv
// full_adder_13bit: the single shared 13-bit ripple-carry adder.
// Ports:
//   x, y       operands
//   cin        carry-in
//   sum        x + y + cin, modulo 2^13
//   cout       carry out of the MSB
//   carry_msb  carry into the MSB (used for signed overflow)
module full_adder_13bit
    import adder_arbiter_pkg::*;
(
    input  logic [ADDER_WIDTH-1:0] x,
    input  logic [ADDER_WIDTH-1:0] y,
    input  logic                   cin,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   carry_msb
);

    logic [ADDER_WIDTH:0] carry_s;

    assign carry_s[0] = cin;

    genvar i;
    generate
        for (i = 0; i < ADDER_WIDTH; i++) begin : g_bit
            assign sum[i]       = x[i] ^ y[i] ^ carry_s[i];
            assign carry_s[i+1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign cout      = carry_s[ADDER_WIDTH];
    assign carry_msb = carry_s[ADDER_WIDTH-1];

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 13-bit adder between the
// reaction-timer increment (A) and the score accumulator (B).
// Ports:
//   Clk, Rst_n              clock, asynchronous active-low reset
//   Req_A/X_A/Y_A/Cin_A     requester A level request and operands
//   Req_B/X_B/Y_B/Cin_B     requester B level request and operands
//   Gnt_A, Gnt_B            owner indication during EXEC and DONE
//   Done_A, Done_B          one-cycle result-valid pulse for the owner
//   Sum, Cout, Overflow     registered adder results, held until next add
//   Busy                    arbiter is not idle
// Flow: IDLE (pick winner, latch operands) -> EXEC (adder runs on the
// latched operands, results captured) -> DONE (Done pulse) -> IDLE.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int   WIDTH      = 13,
    parameter logic START_PRIO = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req_A,
    input  logic [WIDTH-1:0] X_A,
    input  logic [WIDTH-1:0] Y_A,
    input  logic             Cin_A,
    input  logic             Req_B,
    input  logic [WIDTH-1:0] X_B,
    input  logic [WIDTH-1:0] Y_B,
    input  logic             Cin_B,
    output logic             Gnt_A,
    output logic             Gnt_B,
    output logic             Done_A,
    output logic             Done_B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy
);

    // The shared adder has a fixed width; any other WIDTH is rejected.
    generate
        if (WIDTH != ADDER_WIDTH) begin : g_width_check
            $error("adder_arbiter: WIDTH must equal 13");
        end
    endgenerate

    arb_state_t       state_r;
    arb_state_t       next_state_s;
    logic             grant_s;
    logic             win_owner_s;
    logic             next_owner_s;
    logic [WIDTH-1:0] win_x_s;
    logic [WIDTH-1:0] win_y_s;
    logic             win_cin_s;

    logic [WIDTH-1:0] op_x_r;
    logic [WIDTH-1:0] op_y_r;
    logic             op_cin_r;
    logic             owner_r;
    logic             ptr_r;

    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             busy_r;
    logic             done_a_r;
    logic             done_b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [WIDTH-1:0] add_sum_s;
    logic             add_cout_s;
    logic             add_cmsb_s;

    // Next-state and winner selection; requests are only looked at in IDLE.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        win_owner_s  = OWN_A;
        case (state_r)
            IDLE: begin
                if (Req_A && Req_B) begin
                    grant_s     = 1'b1;
                    win_owner_s = ptr_r;
                end else if (Req_A) begin
                    grant_s     = 1'b1;
                    win_owner_s = OWN_A;
                end else if (Req_B) begin
                    grant_s     = 1'b1;
                    win_owner_s = OWN_B;
                end else begin
                    grant_s     = 1'b0;
                    win_owner_s = OWN_A;
                end
                if (grant_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC:    next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Operand mux for the winning requester and the owner seen next cycle.
    always_comb begin
        win_x_s      = X_A;
        win_y_s      = Y_A;
        win_cin_s    = Cin_A;
        next_owner_s = owner_r;
        if (win_owner_s == OWN_B) begin
            win_x_s   = X_B;
            win_y_s   = Y_B;
            win_cin_s = Cin_B;
        end else begin
            win_x_s   = X_A;
            win_y_s   = Y_A;
            win_cin_s = Cin_A;
        end
        if (grant_s) begin
            next_owner_s = win_owner_s;
        end else begin
            next_owner_s = owner_r;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture at grant time; the adder never sees live ports.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_x_r   <= {WIDTH{1'b0}};
            op_y_r   <= {WIDTH{1'b0}};
            op_cin_r <= 1'b0;
            owner_r  <= OWN_A;
        end else if (grant_s) begin
            op_x_r   <= win_x_s;
            op_y_r   <= win_y_s;
            op_cin_r <= win_cin_s;
            owner_r  <= win_owner_s;
        end else begin
            op_x_r   <= op_x_r;
            op_y_r   <= op_y_r;
            op_cin_r <= op_cin_r;
            owner_r  <= owner_r;
        end
    end

    // Grant and busy flags, registered from the next state so they track EXEC/DONE.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            busy_r  <= (next_state_s != IDLE);
            gnt_a_r <= (next_state_s != IDLE) && (next_owner_s == OWN_A);
            gnt_b_r <= (next_state_s != IDLE) && (next_owner_s == OWN_B);
        end
    end

    // Result capture, Done pulse and pointer hand-off at the end of EXEC.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            done_a_r <= 1'b0;
            done_b_r <= 1'b0;
            ptr_r    <= START_PRIO;
        end else if (state_r == EXEC) begin
            sum_r    <= add_sum_s;
            cout_r   <= add_cout_s;
            ovf_r    <= twos_overflow(add_cmsb_s, add_cout_s);
            done_a_r <= (owner_r == OWN_A);
            done_b_r <= (owner_r == OWN_B);
            ptr_r    <= ~owner_r;
        end else begin
            sum_r    <= sum_r;
            cout_r   <= cout_r;
            ovf_r    <= ovf_r;
            done_a_r <= 1'b0;
            done_b_r <= 1'b0;
            ptr_r    <= ptr_r;
        end
    end

    full_adder_13bit u_adder (
        .x         (op_x_r),
        .y         (op_y_r),
        .cin       (op_cin_r),
        .sum       (add_sum_s),
        .cout      (add_cout_s),
        .carry_msb (add_cmsb_s)
    );

    assign Gnt_A    = gnt_a_r;
    assign Gnt_B    = gnt_b_r;
    assign Done_A   = done_a_r;
    assign Done_B   = done_b_r;
    assign Sum      = sum_r;
    assign Cout     = cout_r;
    assign Overflow = ovf_r;
    assign Busy     = busy_r;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one full_adder_13bit instance between two requesters in the reaction-time game:
  - Requester A: the reaction timer millisecond increment.
  - Requester B: the score/total-time accumulator.
- Provides round-robin arbitration, a level request / pulsed done handshake and registered results.
- Sits between the game FSM datapath and the single 13-bit ripple adder, so only one adder is instantiated in the design.

Parameters:
- WIDTH, 13, operand/result width; fixed at 13 to match full_adder_13bit; any other value is a synthesis error.
- START_PRIO, 0, requester favoured on the first contended cycle after reset (0=A, 1=B).

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Req_A  input  1  requester A wants an add; level, held until Done_A.
- X_A  input  WIDTH  A operand X.
- Y_A  input  WIDTH  A operand Y.
- Cin_A  input  1  A carry-in.
- Req_B  input  1  requester B wants an add; level, held until Done_B.
- X_B  input  WIDTH  B operand X.
- Y_B  input  WIDTH  B operand Y.
- Cin_B  input  1  B carry-in.
- Gnt_A  output  1  A owns the adder (EXEC and DONE states).
- Gnt_B  output  1  B owns the adder.
- Done_A  output  1  one-cycle pulse; result belongs to A.
- Done_B  output  1  one-cycle pulse; result belongs to B.
- Sum  output  WIDTH  registered adder sum.
- Cout  output  1  registered carry-out.
- Overflow  output  1  registered two's-complement overflow (carry into MSB XOR carry out).
- Busy  output  1  state != IDLE.

Behaviour:
- Reset (async, Rst_n low): state=IDLE; all outputs 0; operand regs 0; priority pointer=START_PRIO. Reset mid-operation aborts silently: no Done is issued, and the requester must re-request.
- States: IDLE, EXEC, DONE.
- IDLE:
  - If only one Req is high, that requester wins.
  - If both are high, the requester indicated by the pointer wins.
  - On a win: latch the winner's X/Y/Cin into operand regs, record owner, go to EXEC.
  - If no Req is high, stay in IDLE.
- EXEC:
  - Adder inputs are the latched operand regs, never the live ports; operand changes during EXEC have no effect.
  - At the clock edge: Sum/Cout/Overflow load from the adder, the owner's Done is set, the pointer is set to the non-owner, state goes to DONE.
- DONE:
  - Owner's Done=1 for exactly this cycle; Req inputs are ignored.
  - Next edge: Done clears, state goes to IDLE.
- Latency: Req sampled high in IDLE at edge n gives Done high in the cycle after edge n+1 (2 cycles). Throughput is one add per 3 cycles.
- Gnt_x is high in EXEC and DONE for the owner only. Gnt_A and Gnt_B are never both high.
- Requesters must deassert Req by the edge following Done. A Req still high in the next IDLE cycle is treated as a new request.
- Sum, Cout and Overflow hold their last value until the next EXEC completes.
- Fairness: under continuous contention, grants strictly alternate A, B, A, B. An uncontended request does not update the pointer differently; the pointer always becomes the non-owner.
- Req dropped during EXEC or DONE: the operation still completes and Done still pulses.
- Width rule: no extension or saturation. Sum is mod 2^13. Cout and Overflow are passed straight from the adder.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, EXEC=2'd1, DONE=2'd2), owner constants (OWN_A=1'b0, OWN_B=1'b1), ADDER_WIDTH=13.
- One sub-module: full_adder_13bit, instantiated once and fed from the operand registers.
- Arbitration and muxing stay inline; no further sub-modules.

Test Plan:
- Reset with Req_A=1 held: while Rst_n=0, all outputs 0 and Busy=0. After release, Gnt_A rises one cycle later and Done_A follows one cycle after that.
- A only, X_A=13'h0FFF, Y_A=1, Cin_A=0 -> Done_A pulse; Sum=13'h1000, Cout=0, Overflow=1.
- B only, X_B=13'h1FFF, Y_B=0, Cin_B=1 -> Done_B; Sum=0, Cout=1, Overflow=0; Gnt_A stays 0.
- Req_A and Req_B both held continuously for 4 operations (START_PRIO=0, A: 100+23, B: 500+12) -> grant order A, B, A, B; results 123, 512, 123, 512; never two Gnt high together.
- Operand change during EXEC (X_A from 5 to 9, Y_A=3) -> Sum=8, not 12.
- Rst_n pulsed low during EXEC -> no Done pulse, outputs 0, state IDLE, pointer=START_PRIO.
